// File: rtl/alu_ctrl_seq_if.sv
// Decode-request / ALU-control-beat handshake bundle for alu_ctrl_seq.
// The slave modport is the sequencer; the master modport is its requester/datapath side.
interface alu_ctrl_seq_if #(
    parameter int FUNCT_W = 2,
    parameter int SHAMT_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         alu_op;
    logic [FUNCT_W-1:0] funct;
    logic [3:0]         opcode;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         alu_ctrl;
    logic               step_last;
    logic               illegal;

    modport slave (
        input  in_valid, alu_op, funct, opcode, shamt, out_ready,
        output in_ready, out_valid, alu_ctrl, step_last, illegal
    );

    modport master (
        output in_valid, alu_op, funct, opcode, shamt, out_ready,
        input  in_ready, out_valid, alu_ctrl, step_last, illegal
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder that sequences multi-bit shifts as repeated 1-bit shift beats.
// Optional feature: define ALU_CTRL_SEQ_ILLEGAL_EN to flag illegal decodes on the illegal port.
module alu_ctrl_seq #(
    parameter int FUNCT_W = 2,
    parameter int SHAMT_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_ctrl_seq_if.slave bus
);
    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_SLT = 4'b0001;
    localparam logic [3:0] C_OR  = 4'b0010;
    localparam logic [3:0] C_XOR = 4'b0011;
    localparam logic [3:0] C_ADD = 4'b0100;
    localparam logic [3:0] C_SLL = 4'b0110;
    localparam logic [3:0] C_SRA = 4'b0111;
    localparam logic [3:0] C_SUB = 4'b1100;

`ifdef ALU_CTRL_SEQ_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic               ill_q, ill_d;

    logic [3:0] dec_code;
    logic       dec_shift;
    logic       dec_ill;
    logic       accept, hs, last;

    // Illegal decodes fall back to ADD so the datapath always sees a harmless op.
    always_comb begin
        dec_code  = C_ADD;
        dec_shift = 1'b0;
        dec_ill   = 1'b0;
        case (bus.alu_op)
            2'b00: dec_code = C_ADD;
            2'b01: dec_code = C_SUB;
            2'b11: begin
                case (bus.opcode)
                    4'b1001: dec_code = C_ADD;
                    4'b1010: dec_code = C_SUB;
                    4'b1011: dec_code = C_SLT;
                    default: dec_ill  = 1'b1;
                endcase
            end
            default: begin
                if (bus.funct == FUNCT_W'(0)) begin
                    case (bus.opcode)
                        4'b0000: dec_code = C_AND;
                        4'b0001: dec_code = C_ADD;
                        default: begin dec_code = C_SLL; dec_shift = 1'b1; end
                    endcase
                end else if (bus.funct == FUNCT_W'(1)) begin
                    case (bus.opcode)
                        4'b0000: dec_code = C_OR;
                        4'b0001: dec_code = C_SUB;
                        default: begin dec_code = C_SRA; dec_shift = 1'b1; end
                    endcase
                end else if (bus.funct == FUNCT_W'(2)) begin
                    dec_code = C_XOR;
                end else begin
                    dec_ill = 1'b1;
                end
            end
        endcase
    end

    assign accept = bus.in_valid && bus.in_ready;
    assign hs     = bus.out_valid && bus.out_ready;
    assign last   = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EMIT;
                    ctrl_d  = dec_code;
                    ill_d   = dec_ill && ILL_EN;
                    // counter holds beats remaining after the current one
                    cnt_d   = (dec_shift && bus.shamt != '0) ? bus.shamt - SHAMT_W'(1) : '0;
                end
            end
            default: begin
                if (hs) begin
                    if (last) state_d = IDLE;
                    else      cnt_d   = cnt_q - SHAMT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == EMIT);
    assign bus.alu_ctrl  = bus.out_valid ? ctrl_q : 4'b0000;
    assign bus.step_last = bus.out_valid && last;
    assign bus.illegal   = bus.out_valid && ill_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed + randomized bench for alu_ctrl_seq against a beat-list reference model.
module tb_alu_ctrl_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

`ifdef ALU_CTRL_SEQ_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] c;
        logic       l;
        logic       il;
    } beat_t;

    beat_t exp_q[$];

    alu_ctrl_seq_if #(.FUNCT_W(2), .SHAMT_W(4)) bus ();

    alu_ctrl_seq #(.FUNCT_W(2), .SHAMT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the request turns into a list of beats, straight from the decode table.
    task automatic model(input logic [1:0] aop, input logic [1:0] fn, input logic [3:0] opc,
                         input logic [3:0] sh);
        int    code  = 4;
        bit    shift = 0;
        bit    ill   = 0;
        int    n;
        beat_t b;
        if (aop == 0) code = 4;
        else if (aop == 1) code = 12;
        else if (aop == 3) begin
            if (opc == 9) code = 4;
            else if (opc == 10) code = 12;
            else if (opc == 11) code = 1;
            else ill = 1;
        end else begin
            if (fn == 0) begin
                if (opc == 0) code = 0; else if (opc == 1) code = 4; else begin code = 6; shift = 1; end
            end else if (fn == 1) begin
                if (opc == 0) code = 2; else if (opc == 1) code = 12; else begin code = 7; shift = 1; end
            end else if (fn == 2) code = 3;
            else ill = 1;
        end
        n = (shift && sh > 0) ? int'(sh) : 1;
        exp_q.delete();
        for (int i = 1; i <= n; i++) begin
            b.c  = 4'(code);
            b.l  = (i == n);
            b.il = ill && ILL_EN;
            exp_q.push_back(b);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_req(input logic [1:0] aop, input logic [1:0] fn, input logic [3:0] opc,
                          input logic [3:0] sh, input int rdy_pct, input int stall_first,
                          input bit busy_poke, input int abort_after);
        int beats = 0;
        int stl   = stall_first;
        bit rdy;
        model(aop, fn, opc, sh);
        chk("idle_ready", bus.in_ready, 1);
        chk("idle_valid", bus.out_valid, 0);
        bus.in_valid = 1'b1;
        bus.alu_op   = aop;
        bus.funct    = fn;
        bus.opcode   = opc;
        bus.shamt    = sh;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (busy_poke) begin
            bus.alu_op = 2'b00;
            bus.funct  = 2'($urandom);
            bus.opcode = 4'($urandom);
            bus.shamt  = 4'($urandom);
        end else begin
            bus.in_valid = 1'b0;
        end
        for (int cyc = 0; cyc < 400 && exp_q.size() > 0; cyc++) begin
            chk("beat_valid", bus.out_valid, 1);
            chk("beat_ctrl", bus.alu_ctrl, exp_q[0].c);
            chk("beat_last", bus.step_last, exp_q[0].l);
            chk("beat_illegal", bus.illegal, exp_q[0].il);
            chk("busy_ready", bus.in_ready, 0);
            if (abort_after > 0 && beats == abort_after) begin
                rst_n = 1'b0;
                bus.in_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("rst_valid", bus.out_valid, 0);
                chk("rst_ready", bus.in_ready, 0);
                chk("rst_ctrl", bus.alu_ctrl, 0);
                rst_n = 1'b1;
                exp_q.delete();
                @(posedge clk);
                @(negedge clk);
                break;
            end
            if (stl > 0) begin rdy = 1'b0; stl--; end
            else rdy = ($urandom_range(0, 99) < rdy_pct);
            bus.out_ready = rdy;
            if (rdy) begin
                if (exp_q[0].l) bus.in_valid = 1'b0;
                void'(exp_q.pop_front());
                beats++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("drained", exp_q.size(), 0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("after_valid", bus.out_valid, 0);
        chk("after_ready", bus.in_ready, 1);
        chk("after_ctrl", bus.alu_ctrl, 0);
        chk("after_last", bus.step_last, 0);
        // nothing may appear without a fresh accept
        @(posedge clk);
        @(negedge clk);
        chk("quiet_valid", bus.out_valid, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_op    = '0;
        bus.funct     = '0;
        bus.opcode    = '0;
        bus.shamt     = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ready", bus.in_ready, 0);
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_ctrl", bus.alu_ctrl, 0);
        chk("reset_last", bus.step_last, 0);
        chk("reset_illegal", bus.illegal, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_ready", bus.in_ready, 1);

        do_req(2'b10, 2'd0, 4'b0001, 4'd5, 100, 0, 0, 0);   // funct0/opcode1 -> ADD single beat
        do_req(2'b10, 2'd1, 4'b0011, 4'd3, 100, 0, 0, 0);   // SRA x3
        do_req(2'b10, 2'd0, 4'b0101, 4'd2, 100, 4, 0, 0);   // SLL x2, first beat stalled
        do_req(2'b11, 2'd0, 4'b1111, 4'd0, 100, 0, 0, 0);   // illegal opcode
        do_req(2'b10, 2'd3, 4'b0000, 4'd0, 100, 0, 0, 0);   // illegal funct
        do_req(2'b10, 2'd1, 4'b0110, 4'd15, 100, 0, 0, 5);  // SRA x15, reset after 5 beats
        do_req(2'b10, 2'd0, 4'b0111, 4'd0, 100, 0, 1, 0);   // SLL shamt 0, poke while busy
        do_req(2'b10, 2'd0, 4'b0010, 4'd15, 70, 0, 1, 0);   // max shamt with stalls
        do_req(2'b00, 2'd2, 4'b0000, 4'd0, 100, 0, 0, 0);
        do_req(2'b01, 2'd2, 4'b0000, 4'd0, 100, 0, 0, 0);
        do_req(2'b11, 2'd0, 4'b1001, 4'd0, 100, 0, 0, 0);
        do_req(2'b11, 2'd0, 4'b1010, 4'd0, 100, 0, 0, 0);
        do_req(2'b11, 2'd0, 4'b1011, 4'd0, 100, 0, 0, 0);
        do_req(2'b10, 2'd0, 4'b0000, 4'd0, 100, 0, 0, 0);
        do_req(2'b10, 2'd1, 4'b0000, 4'd0, 100, 0, 0, 0);
        do_req(2'b10, 2'd1, 4'b0001, 4'd0, 100, 0, 0, 0);
        do_req(2'b10, 2'd2, 4'b1100, 4'd7, 100, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] opc;
            opc = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
            if ($urandom_range(0, 1) == 0) opc = 4'($urandom_range(9, 12));
            do_req(2'($urandom), 2'($urandom), opc, 4'($urandom_range(0, 6)),
                   int'($urandom_range(40, 100)), int'($urandom_range(0, 2)),
                   1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
